// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the iterative divider sequencer.
//   - DIV_W_DEF  : default operand width
//   - div_st_e   : 2-bit FSM state encoding (IDLE/CALC/FIX/DONE)
package div_ctrl_pkg;

  localparam int DIV_W_DEF = 32;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_st_e;

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step.
// Ports:
//   rq_i   [2*DIV_W] : current {remainder, quotient} shift register
//   dvsr_i [DIV_W]   : divisor magnitude
//   rq_o   [2*DIV_W] : next {remainder, quotient}
module div_iter_step #(
  parameter int DIV_W = 32
) (
  input  logic [2*DIV_W-1:0] rq_i,
  input  logic [DIV_W-1:0]   dvsr_i,
  output logic [2*DIV_W-1:0] rq_o
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // The partial remainder shifted left by one needs DIV_W+1 bits: with an
  // unsigned divisor above 2^(DIV_W-1) the remainder MSB can be set, and
  // dropping it would corrupt the trial subtraction.
  assign shifted = rq_i[2*DIV_W-1:DIV_W-1];
  assign trial   = shifted - {1'b0, dvsr_i};

  always_comb begin
    rq_o = {shifted[DIV_W-1:0], rq_i[DIV_W-2:0], 1'b0};
    // A clear MSB means no borrow: the divisor fits, keep the difference.
    if (!trial[DIV_W]) begin
      rq_o = {trial[DIV_W-1:0], rq_i[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: iterative divider sequencer for the execute stage.
// Accepts a divide while EXE holds it, runs DIV_W restoring steps on operand
// magnitudes, fixes signs, then holds the result with div_complete high until
// EXE hands the instruction to MEM.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   div_enable     : EXE holds a valid divide
//   div_sign       : 1 = signed, 0 = unsigned
//   div_src1/2     : dividend / divisor
//   div_taken      : EXE transfers the instruction to MEM this cycle
//   div_complete   : results valid
//   div_quotient   : quotient
//   div_remainder  : remainder (sign follows dividend)
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_enable,
  input  logic             div_sign,
  input  logic [DIV_W-1:0] div_src1,
  input  logic [DIV_W-1:0] div_src2,
  input  logic             div_taken,
  output logic             div_complete,
  output logic [DIV_W-1:0] div_quotient,
  output logic [DIV_W-1:0] div_remainder
);

  localparam int CNT_W = $clog2(DIV_W);

  div_st_e            state_q, state_d;
  logic [2*DIV_W-1:0] rq_q, rq_step;
  logic [DIV_W-1:0]   dvsr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               q_neg_q, r_neg_q;

  logic               s1, s2;
  logic               dvsr_zero;
  logic               cnt_last;
  logic [DIV_W-1:0]   rem_cur, quo_cur;

  // Two's-complement magnitude when the operand is a negative signed value.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v,
                                           input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign s1        = div_sign & div_src1[DIV_W-1];
  assign s2        = div_sign & div_src2[DIV_W-1];
  assign dvsr_zero = (div_src2 == '0);
  assign cnt_last  = (cnt_q == CNT_W'(DIV_W - 1));
  assign rem_cur   = rq_q[2*DIV_W-1:DIV_W];
  assign quo_cur   = rq_q[DIV_W-1:0];

  div_iter_step #(.DIV_W(DIV_W)) u_step (
    .rq_i   (rq_q),
    .dvsr_i (dvsr_q),
    .rq_o   (rq_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping div_enable mid-operation aborts the divide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_ST_IDLE: if (div_enable) state_d = dvsr_zero ? DIV_ST_DONE : DIV_ST_CALC;
      DIV_ST_CALC: begin
        if (!div_enable)   state_d = DIV_ST_IDLE;
        else if (cnt_last) state_d = DIV_ST_FIX;
      end
      DIV_ST_FIX:  state_d = div_enable ? DIV_ST_DONE : DIV_ST_IDLE;
      DIV_ST_DONE: if (div_taken || !div_enable) state_d = DIV_ST_IDLE;
      default:     state_d = DIV_ST_IDLE;
    endcase
  end

  // Outputs: complete is a decode of the registered state; results come
  // straight from the shift register, which holds still outside CALC/FIX.
  always_comb begin
    div_complete  = (state_q == DIV_ST_DONE);
    div_quotient  = quo_cur;
    div_remainder = rem_cur;
  end

  // Datapath: operand capture, iteration, sign fix-up
  always_ff @(posedge clk) begin
    if (reset) begin
      rq_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (div_enable) begin
            dvsr_q  <= mag(div_src2, s2);
            q_neg_q <= s1 ^ s2;
            r_neg_q <= s1;
            cnt_q   <= '0;
            // Divide-by-zero: result is decided immediately, no iteration.
            if (dvsr_zero) rq_q <= {div_src1, {DIV_W{1'b1}}};
            else           rq_q <= {{DIV_W{1'b0}}, mag(div_src1, s1)};
          end
        end
        DIV_ST_CALC: begin
          rq_q  <= rq_step;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DIV_ST_FIX: begin
          rq_q <= {mag(rem_cur, r_neg_q), mag(quo_cur, q_neg_q)};
        end
        default: ;
      endcase
    end
  end

endmodule
